// File: rtl/pkt_buf_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pkt_buf_pkg
// Description : Shared types and constants for the packet store buffer:
//               replay FSM state encoding and Ethernet frame length limits.
// Revision    : 1.0 - initial release
// ============================================================================
package pkt_buf_pkg;

  // Replay-side FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } rd_state_t;

  // Default frame length window (bytes)
  localparam int ETH_MIN_LEN = 64;
  localparam int ETH_MAX_LEN = 1518;

endpackage : pkt_buf_pkg
`default_nettype wire

// File: rtl/pkt_sdp_ram.sv
`default_nettype none
// ============================================================================
// Module      : pkt_sdp_ram
// Description : Simple dual-port RAM, one write port and one read port,
//               synchronous read with one cycle of latency.
// Ports       : iclk       - clock
//               wr_en_i    - write enable
//               wr_addr_i  - write address
//               wr_data_i  - write data
//               rd_addr_i  - read address (sampled every cycle)
//               rd_data_o  - read data, valid the cycle after rd_addr_i
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_sdp_ram #(
  parameter int pDATA_W = 8,
  parameter int pADDR_W = 14
) (
  input  logic               iclk,
  input  logic               wr_en_i,
  input  logic [pADDR_W-1:0] wr_addr_i,
  input  logic [pDATA_W-1:0] wr_data_i,
  input  logic [pADDR_W-1:0] rd_addr_i,
  output logic [pDATA_W-1:0] rd_data_o
);

  logic [pDATA_W-1:0] mem_q [2**pADDR_W];

  always_ff @(posedge iclk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_o <= mem_q[rd_addr_i];
  end

endmodule : pkt_sdp_ram
`default_nettype wire

// File: rtl/pkt_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : pkt_store_buffer
// Description : Stores RX MAC frames in a circular data RAM, commits only
//               good frames (queueing {start, length} in a length FIFO),
//               drops bad/oversize/overflowing frames by rewinding the write
//               pointer, and replays committed frames on request.
// Ports       : iclk, i_rst        - clock, async active-high reset
//               idv, irx_d         - RX byte stream
//               i_error            - RX error, sticky for the frame
//               i_eop, i_crc_ok    - end-of-frame pulse and CRC verdict
//               i_rd_req           - replay oldest committed frame
//               o_len, o_len_vld   - head-of-queue length / queue non-empty
//               o_data, o_dv       - replay byte stream
//               o_sop, o_eop       - first / last replay byte markers
//               o_drop_cnt         - saturating dropped-frame count
//               o_full             - data RAM or length FIFO full (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_store_buffer
  import pkt_buf_pkg::*;
#(
  parameter int pDATA_W  = 8,
  parameter int pADDR_W  = 14,
  parameter int pLEN_W   = 11,
  parameter int pQ_AW    = 2,
  parameter int pMIN_LEN = ETH_MIN_LEN,
  parameter int pMAX_LEN = ETH_MAX_LEN
) (
  input  logic               iclk,
  input  logic               i_rst,
  input  logic               idv,
  input  logic [pDATA_W-1:0] irx_d,
  input  logic               i_error,
  input  logic               i_eop,
  input  logic               i_crc_ok,
  input  logic               i_rd_req,
  output logic [pLEN_W-1:0]  o_len,
  output logic               o_len_vld,
  output logic [pDATA_W-1:0] o_data,
  output logic               o_dv,
  output logic               o_sop,
  output logic               o_eop,
  output logic [15:0]        o_drop_cnt,
  output logic               o_full
);

  localparam int PW = pADDR_W + 1;
  localparam int QD = 2**pQ_AW;
  localparam logic [PW-1:0]     DEPTH_P = {1'b1, {pADDR_W{1'b0}}};
  localparam logic [pLEN_W-1:0] MIN_L   = pLEN_W'(pMIN_LEN);
  localparam logic [pLEN_W-1:0] MAX_L   = pLEN_W'(pMAX_LEN);

  typedef struct packed {
    logic [pADDR_W-1:0] start_addr;
    logic [pLEN_W-1:0]  len;
  } len_entry_t;

  // Write side state
  logic [PW-1:0]      wr_ptr_q, commit_ptr_q, rd_ptr_q;
  logic [pLEN_W-1:0]  frame_len_q;
  logic               err_q, ovf_q, full_q;
  logic [15:0]        drop_cnt_q;

  // Length FIFO
  len_entry_t         fifo_mem_q [QD];
  logic [pQ_AW-1:0]   fifo_wp_q, fifo_rp_q;
  logic [pQ_AW:0]     fifo_cnt_q;

  // Replay FSM
  rd_state_t          state_q, state_d;
  logic [pADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [pLEN_W-1:0]  beat_q, beat_d;

  logic               w_ram_full, w_fifo_full, w_len_ok, w_commit, w_pop, w_last, w_len_vld;
  logic [PW-1:0]      w_used;
  len_entry_t         w_head, w_new_entry;
  logic [pADDR_W-1:0] w_head_addr, w_raddr;
  logic [pLEN_W-1:0]  w_head_len;
  logic [pDATA_W-1:0] w_ram_rd;

  // Uncommitted bytes count against free space, so an in-flight frame
  // can never overwrite data still waiting to be replayed.
  assign w_used      = wr_ptr_q - rd_ptr_q;
  assign w_ram_full  = (w_used == DEPTH_P);
  assign w_fifo_full = fifo_cnt_q[pQ_AW];
  assign w_len_vld   = (fifo_cnt_q != '0);
  assign w_len_ok    = (frame_len_q >= MIN_L) && (frame_len_q <= MAX_L);
  assign w_commit    = i_eop & i_crc_ok & ~err_q & ~i_error & ~ovf_q & w_len_ok & ~w_fifo_full;

  // A frame always starts at the last commit point, since drops rewind to it.
  assign w_new_entry = '{start_addr: commit_ptr_q[pADDR_W-1:0], len: frame_len_q};

  assign w_head      = fifo_mem_q[fifo_rp_q];
  assign w_head_addr = w_head.start_addr;
  assign w_head_len  = w_head.len;
  assign w_last      = (state_q == STREAM) && (beat_q == w_head_len - pLEN_W'(1));
  assign w_pop       = w_last;
  assign w_raddr     = (state_q == LOAD) ? w_head_addr : rd_addr_q;

  pkt_sdp_ram #(
    .pDATA_W (pDATA_W),
    .pADDR_W (pADDR_W)
  ) u_ram (
    .iclk      (iclk),
    .wr_en_i   (idv & ~i_eop & ~w_ram_full),
    .wr_addr_i (wr_ptr_q[pADDR_W-1:0]),
    .wr_data_i (irx_d),
    .rd_addr_i (w_raddr),
    .rd_data_o (w_ram_rd)
  );

  always_ff @(posedge iclk) begin
    if (w_commit) begin
      fifo_mem_q[fifo_wp_q] <= w_new_entry;
    end
  end

  always_ff @(posedge iclk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      frame_len_q  <= '0;
      err_q        <= 1'b0;
      ovf_q        <= 1'b0;
      full_q       <= 1'b0;
      drop_cnt_q   <= '0;
      fifo_wp_q    <= '0;
      fifo_rp_q    <= '0;
      fifo_cnt_q   <= '0;
      state_q      <= IDLE;
      rd_addr_q    <= '0;
      beat_q       <= '0;
    end else begin
      if (i_eop) begin
        frame_len_q <= '0;
        err_q       <= 1'b0;
        ovf_q       <= 1'b0;
        if (w_commit) begin
          commit_ptr_q <= wr_ptr_q;
        end else begin
          wr_ptr_q <= commit_ptr_q;
          if (drop_cnt_q != 16'hFFFF) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
          end
        end
      end else begin
        if (idv) begin
          if (frame_len_q != '1) begin
            frame_len_q <= frame_len_q + pLEN_W'(1);
          end
          // Byte lost to a full RAM: remember it so the frame is dropped at eop.
          if (w_ram_full) begin
            ovf_q <= 1'b1;
          end else begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
          end
        end
        if (i_error) begin
          err_q <= 1'b1;
        end
      end

      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(w_head_len);
      end
      full_q <= w_ram_full | w_fifo_full;

      if (w_commit) fifo_wp_q <= fifo_wp_q + pQ_AW'(1);
      if (w_pop)    fifo_rp_q <= fifo_rp_q + pQ_AW'(1);
      case ({w_commit, w_pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + (pQ_AW+1)'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - (pQ_AW+1)'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase

      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      beat_q    <= beat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    beat_d    = beat_q;
    case (state_q)
      IDLE: begin
        if (i_rd_req && w_len_vld) state_d = LOAD;
      end
      LOAD: begin
        // Head address goes to the RAM this cycle; keep fetching one ahead.
        rd_addr_d = w_head_addr + pADDR_W'(1);
        beat_d    = '0;
        state_d   = STREAM;
      end
      STREAM: begin
        rd_addr_d = rd_addr_q + pADDR_W'(1);
        beat_d    = beat_q + pLEN_W'(1);
        if (w_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_dv       = (state_q == STREAM);
  assign o_sop      = o_dv && (beat_q == '0);
  assign o_eop      = w_last;
  assign o_data     = o_dv ? w_ram_rd : '0;
  assign o_len_vld  = w_len_vld;
  assign o_len      = w_len_vld ? w_head_len : '0;
  assign o_drop_cnt = drop_cnt_q;
  assign o_full     = full_q;

endmodule : pkt_store_buffer
`default_nettype wire

// File: tb/tb_pkt_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pkt_store_buffer
// Description : Directed self-checking bench for pkt_store_buffer. Instance 0
//               uses default parameters, instance 1 a 256-byte data RAM; both
//               share the same stimulus, and each step checks the instance
//               it targets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pkt_store_buffer;

  logic        iclk = 1'b0;
  logic        i_rst = 1'b1;
  logic        idv = 1'b0;
  logic [7:0]  irx_d = 8'h00;
  logic        i_error = 1'b0;
  logic        i_eop = 1'b0;
  logic        i_crc_ok = 1'b0;
  logic        i_rd_req = 1'b0;

  logic [10:0] len_o  [2];
  logic        lvld_o [2];
  logic [7:0]  data_o [2];
  logic        dv_o   [2];
  logic        sop_o  [2];
  logic        eop_o  [2];
  logic [15:0] drop_o [2];
  logic        full_o [2];

  int   n_cmp = 0;
  int   n_mis = 0;
  logic full_seen = 1'b0;

  always #5 iclk = ~iclk;

  pkt_store_buffer u_dut0 (
    .iclk(iclk), .i_rst(i_rst), .idv(idv), .irx_d(irx_d), .i_error(i_error),
    .i_eop(i_eop), .i_crc_ok(i_crc_ok), .i_rd_req(i_rd_req),
    .o_len(len_o[0]), .o_len_vld(lvld_o[0]), .o_data(data_o[0]), .o_dv(dv_o[0]),
    .o_sop(sop_o[0]), .o_eop(eop_o[0]), .o_drop_cnt(drop_o[0]), .o_full(full_o[0])
  );

  pkt_store_buffer #(.pADDR_W(8)) u_dut1 (
    .iclk(iclk), .i_rst(i_rst), .idv(idv), .irx_d(irx_d), .i_error(i_error),
    .i_eop(i_eop), .i_crc_ok(i_crc_ok), .i_rd_req(i_rd_req),
    .o_len(len_o[1]), .o_len_vld(lvld_o[1]), .o_data(data_o[1]), .o_dv(dv_o[1]),
    .o_sop(sop_o[1]), .o_eop(eop_o[1]), .o_drop_cnt(drop_o[1]), .o_full(full_o[1])
  );

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    tick();
  endtask

  // Bytes are seed, seed+1, ...; err_at < 0 means no error pulse.
  task automatic send_frame(input int len, input logic [7:0] seed, input int err_at, input logic crc);
    for (int i = 0; i < len; i++) begin
      idv     = 1'b1;
      irx_d   = 8'(seed + i);
      i_error = (i == err_at);
      tick();
      if (full_o[1] === 1'b1) full_seen = 1'b1;
    end
    idv      = 1'b0;
    i_error  = 1'b0;
    i_eop    = 1'b1;
    i_crc_ok = crc;
    tick();
    i_eop    = 1'b0;
    i_crc_ok = 1'b0;
  endtask

  // Request a replay and check every beat as {dv, sop, eop, data}.
  task automatic replay(input int u, input int len, input logic [7:0] seed, input string tag);
    i_rd_req = 1'b1;
    tick();
    i_rd_req = 1'b0;
    chk({tag, "_load_dv"}, 32'(dv_o[u]), 32'd0);
    tick();
    for (int b = 0; b < len; b++) begin
      chk({tag, "_beat"}, {dv_o[u], sop_o[u], eop_o[u], data_o[u]},
          {1'b1, (b == 0), (b == len - 1), 8'(seed + b)});
      tick();
    end
    chk({tag, "_end_dv"}, 32'(dv_o[u]), 32'd0);
  endtask

  task automatic chk_zero(input int u, input string tag);
    chk({tag, "_len"},  32'(len_o[u]),  32'd0);
    chk({tag, "_lvld"}, 32'(lvld_o[u]), 32'd0);
    chk({tag, "_data"}, 32'(data_o[u]), 32'd0);
    chk({tag, "_dv"},   32'(dv_o[u]),   32'd0);
    chk({tag, "_sop"},  32'(sop_o[u]),  32'd0);
    chk({tag, "_eop"},  32'(eop_o[u]),  32'd0);
    chk({tag, "_drop"}, 32'(drop_o[u]), 32'd0);
    chk({tag, "_full"}, 32'(full_o[u]), 32'd0);
  endtask

  initial begin
    // Reset state
    i_rst = 1'b1;
    tick();
    tick();
    chk_zero(0, "rst");
    i_rst = 1'b0;
    tick();

    // Single good 100-byte frame
    send_frame(100, 8'h10, -1, 1'b1);
    chk("f1_lvld", 32'(lvld_o[0]), 32'd1);
    chk("f1_len",  32'(len_o[0]),  32'd100);
    replay(0, 100, 8'h10, "f1");
    chk("f1_empty", 32'(lvld_o[0]), 32'd0);

    // Error at byte 40 drops the frame; next frame reuses its start address
    send_frame(100, 8'h30, 40, 1'b1);
    chk("err_drop", 32'(drop_o[0]), 32'd1);
    chk("err_lvld", 32'(lvld_o[0]), 32'd0);
    chk("err_wptr", 32'(u_dut0.wr_ptr_q), 32'd100);
    send_frame(80, 8'h55, -1, 1'b1);
    chk("f3_len",   32'(len_o[0]), 32'd80);
    chk("f3_start", 32'(u_dut0.w_head_addr), 32'd100);
    replay(0, 80, 8'h55, "f3");

    // Length boundaries
    send_frame(63,   8'h01, -1, 1'b1);
    send_frame(1519, 8'h02, -1, 1'b1);
    chk("bnd_drop", 32'(drop_o[0]), 32'd3);
    chk("bnd_lvld", 32'(lvld_o[0]), 32'd0);
    send_frame(64,   8'h40, -1, 1'b1);
    send_frame(1518, 8'h80, -1, 1'b1);
    chk("bnd_drop2", 32'(drop_o[0]), 32'd3);
    chk("min_len",   32'(len_o[0]),  32'd64);
    replay(0, 64, 8'h40, "min");
    chk("max_len",   32'(len_o[0]),  32'd1518);
    replay(0, 1518, 8'h80, "max");
    chk("bnd_empty", 32'(lvld_o[0]), 32'd0);

    // Length FIFO fills at 4 entries; the 5th good frame is dropped
    send_frame(100, 8'hA0, -1, 1'b1);
    send_frame(101, 8'hA1, -1, 1'b1);
    send_frame(102, 8'hA2, -1, 1'b1);
    send_frame(103, 8'hA3, -1, 1'b1);
    send_frame(104, 8'hA4, -1, 1'b1);
    chk("q_cnt",  32'(u_dut0.fifo_cnt_q), 32'd4);
    chk("q_drop", 32'(drop_o[0]), 32'd4);
    chk("q_full", 32'(full_o[0]), 32'd1);
    chk("q_len",  32'(len_o[0]),  32'd100);
    replay(0, 100, 8'hA0, "q1");

    // Replay of the 101-byte entry while a 101-byte frame arrives so that
    // its eop coincides with the last replay beat
    i_rd_req = 1'b1;
    tick();
    i_rd_req = 1'b0;
    for (int i = 0; i < 101; i++) begin
      idv   = 1'b1;
      irx_d = 8'(8'hC6 + i);
      tick();
      chk("cc_beat", {dv_o[0], sop_o[0], eop_o[0], data_o[0]},
          {1'b1, (i == 0), (i == 100), 8'(8'hA1 + i)});
    end
    idv      = 1'b0;
    i_eop    = 1'b1;
    i_crc_ok = 1'b1;
    tick();
    i_eop    = 1'b0;
    i_crc_ok = 1'b0;
    chk("cc_cnt",  32'(u_dut0.fifo_cnt_q), 32'd3);
    chk("cc_len",  32'(len_o[0]),  32'd102);
    chk("cc_drop", 32'(drop_o[0]), 32'd4);
    replay(0, 102, 8'hA2, "q3");
    replay(0, 103, 8'hA3, "q4");
    replay(0, 101, 8'hC6, "q6");
    chk("q_empty", 32'(lvld_o[0]), 32'd0);

    // 256-byte RAM: overflow drop, then commit across the address wrap
    do_reset();
    send_frame(200, 8'h20, -1, 1'b1);
    chk("s_len1", 32'(len_o[1]), 32'd200);
    full_seen = 1'b0;
    send_frame(100, 8'h70, -1, 1'b1);
    chk("ovf_full", 32'(full_seen), 32'd1);
    chk("ovf_drop", 32'(drop_o[1]), 32'd1);
    chk("ovf_len",  32'(len_o[1]),  32'd200);
    chk("ovf_wptr", 32'(u_dut1.wr_ptr_q), 32'd200);
    replay(1, 200, 8'h20, "s1");
    send_frame(100, 8'h90, -1, 1'b1);
    chk("wrap_len",  32'(len_o[1]),  32'd100);
    chk("wrap_drop", 32'(drop_o[1]), 32'd1);
    replay(1, 100, 8'h90, "wrap");

    // Reset while streaming
    do_reset();
    send_frame(70, 8'h05, -1, 1'b0);
    send_frame(100, 8'h11, -1, 1'b1);
    chk("pre_drop", 32'(drop_o[0]), 32'd1);
    i_rd_req = 1'b1;
    tick();
    i_rd_req = 1'b0;
    repeat (5) tick();
    chk("pre_dv", 32'(dv_o[0]), 32'd1);
    i_rst = 1'b1;
    #1;
    chk_zero(0, "mid_rst");
    tick();
    i_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_dv",   32'(dv_o[0]),   32'd0);
      chk("post_lvld", 32'(lvld_o[0]), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_pkt_store_buffer
`default_nettype wire
